// File: rtl/nmea_sentence_framer.sv
// Frames AIS NMEA sentences from a UART byte stream, verifies the "*hh" XOR checksum and replays
// good sentences on a valid/ready byte stream. Optional inter-character timeout: NMEA_TIMEOUT_EN.
module nmea_sentence_framer #(
  parameter int MAX_LEN        = 80,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_error,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       sentence_ok,
  output logic       sentence_bad,
  output logic [2:0] err_code
);

  localparam int PW = $clog2(MAX_LEN + 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(MAX_LEN);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_UART    = 3'd1;
  localparam logic [2:0] E_OVF     = 3'd2;
  localparam logic [2:0] E_HEX     = 3'd3;
  localparam logic [2:0] E_CKS     = 3'd4;
  localparam logic [2:0] E_CRLF    = 3'd5;
  localparam logic [2:0] E_RESTART = 3'd6;
  localparam logic [2:0] E_TIMEOUT = 3'd7;

  // S_PREP is the single dead cycle between the LF and the first buffer read.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BODY  = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_CR    = 3'd4,
    S_LF    = 3'd5,
    S_PREP  = 3'd6,
    S_DRAIN = 3'd7
  } state_t;

  state_t        state_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [7:0]    cks_q;
  logic [7:0]    rx_cks_q;
  logic [7:0]    out_data_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          ok_q;
  logic          bad_q;
  logic [2:0]    err_q;

  logic [7:0]    line_mem [MAX_LEN];

  logic          is_start;
  logic          is_star;
  logic          in_frame;
  logic          timeout_hit;
  logic          hex_ok;
  logic [3:0]    hex_nib;
  logic [2:0]    bad_code;
  logic          mem_we;
  logic [PW-1:0] mem_addr;

  assign is_start = (in_data == 8'h21) || (in_data == 8'h24);
  assign is_star  = (in_data == 8'h2A);
  assign in_frame = (state_q == S_BODY) || (state_q == S_HI) || (state_q == S_LO) ||
                    (state_q == S_CR)   || (state_q == S_LF);

  // Upper-case hex only; lower-case letters are rejected as bad digits.
  always_comb begin
    hex_ok  = 1'b0;
    hex_nib = 4'd0;
    if (in_data >= 8'h30 && in_data <= 8'h39) begin
      hex_ok  = 1'b1;
      hex_nib = in_data[3:0];
    end else if (in_data >= 8'h41 && in_data <= 8'h46) begin
      hex_ok  = 1'b1;
      hex_nib = in_data[3:0] + 4'd9;
    end
  end

  // Discard decision for this cycle; a UART error outranks anything carried on in_data.
  always_comb begin
    bad_code = E_NONE;
    if (in_frame) begin
      if (in_error) begin
        bad_code = E_UART;
      end else if (timeout_hit) begin
        bad_code = E_TIMEOUT;
      end else if (in_valid) begin
        case (state_q)
          S_BODY: begin
            if (is_start)                          bad_code = E_RESTART;
            else if (!is_star && wr_ptr_q == PTR_MAX) bad_code = E_OVF;
          end
          S_HI, S_LO: if (!hex_ok)                 bad_code = E_HEX;
          S_CR: if (in_data != 8'h0D)              bad_code = E_CRLF;
          S_LF: begin
            if (in_data != 8'h0A)                  bad_code = E_CRLF;
            else if (rx_cks_q != cks_q)            bad_code = E_CKS;
          end
          default: bad_code = E_NONE;
        endcase
      end
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    if (in_valid && is_start &&
        ((state_q == S_IDLE) || (state_q == S_BODY && !in_error))) begin
      mem_we = 1'b1;
    end else if (state_q == S_BODY && in_valid && !in_error && !is_star &&
                 wr_ptr_q != PTR_MAX) begin
      mem_we   = 1'b1;
      mem_addr = wr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) line_mem[mem_addr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cks_q       <= 8'h00;
      rx_cks_q    <= 8'h00;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ok_q        <= 1'b0;
      bad_q       <= 1'b0;
      err_q       <= E_NONE;
    end else begin
      ok_q  <= 1'b0;
      bad_q <= 1'b0;
      err_q <= E_NONE;
      if (bad_code != E_NONE) begin
        bad_q <= 1'b1;
        err_q <= bad_code;
        if (bad_code == E_RESTART) begin
          state_q  <= S_BODY;
          wr_ptr_q <= PTR_ONE;
          cks_q    <= 8'h00;
        end else begin
          state_q <= S_IDLE;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (in_valid && is_start) begin
              wr_ptr_q <= PTR_ONE;
              cks_q    <= 8'h00;
              state_q  <= S_BODY;
            end
          end
          S_BODY: begin
            if (in_valid) begin
              if (is_star) begin
                state_q <= S_HI;
              end else begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
                cks_q    <= cks_q ^ in_data;
              end
            end
          end
          S_HI: begin
            if (in_valid) begin
              rx_cks_q[7:4] <= hex_nib;
              state_q       <= S_LO;
            end
          end
          S_LO: begin
            if (in_valid) begin
              rx_cks_q[3:0] <= hex_nib;
              state_q       <= S_CR;
            end
          end
          S_CR: if (in_valid) state_q <= S_LF;
          S_LF: begin
            if (in_valid) begin
              ok_q    <= 1'b1;
              state_q <= S_PREP;
            end
          end
          S_PREP: begin
            rd_ptr_q <= '0;
            state_q  <= S_DRAIN;
          end
          S_DRAIN: begin
            if (!out_valid_q || out_ready) begin
              if (out_valid_q && out_last_q) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                state_q     <= S_IDLE;
              end else begin
                out_data_q  <= line_mem[rd_ptr_q];
                out_valid_q <= 1'b1;
                out_last_q  <= (rd_ptr_q == wr_ptr_q - PTR_ONE);
                rd_ptr_q    <= rd_ptr_q + PTR_ONE;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef NMEA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive byte-less cycle inside a sentence.
  assign timeout_hit = in_frame && !in_valid && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else if (!in_frame || in_valid || timeout_hit) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TW'(1);
    end
  end
`else
  // Without the timeout the framer waits forever; TIMEOUT_CYCLES has no effect here.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign sentence_ok  = ok_q;
  assign sentence_bad = bad_q;
  assign err_code     = err_q;

endmodule

// File: tb/tb_nmea_sentence_framer.sv
// Self-checking bench for nmea_sentence_framer: directed sentences from the test plan followed by
// randomized good/bad sentences whose expected events and output bytes come from how they were built.
module tb_nmea_sentence_framer;

  localparam int MAX_LEN = 80;
  localparam int TO_CYC  = 100;
  localparam logic [3:0] EV_OK = 4'h8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_error = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       sentence_ok;
  logic       sentence_bad;
  logic [2:0] err_code;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         rdy_mode = 0;
  bit         gap_en = 1'b0;

  logic [3:0] exp_ev_q[$];
  logic [8:0] exp_byte_q[$];
  logic [7:0] body_q[$];

  nmea_sentence_framer #(
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_error    (in_error),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .sentence_ok (sentence_ok),
    .sentence_bad(sentence_bad),
    .err_code    (err_code)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  // Ready pattern: 0 = always ready, 1 = random, 2 = held low.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (sentence_ok || sentence_bad) begin
      check_eq("ev_expected", 32'(exp_ev_q.size() > 0), 32'd1);
      if (exp_ev_q.size() > 0) check_eq("event", {sentence_ok, err_code}, exp_ev_q.pop_front());
    end else if (err_code != 3'd0) begin
      check_eq("err_code_idle", err_code, 0);
    end
    if (out_valid && out_ready) begin
      check_eq("byte_expected", 32'(exp_byte_q.size() > 0), 32'd1);
      if (exp_byte_q.size() > 0) check_eq("out_byte", {out_last, out_data}, exp_byte_q.pop_front());
    end
  end

  // driver tasks; every task starts and ends just after a falling edge
  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (gap_en && $urandom_range(0, 3) == 0) @(negedge clk);
  endtask

  task automatic send_err();
    in_error = 1'b1;
    in_valid = 1'($urandom_range(0, 1));
    in_data  = 8'($urandom);
    @(negedge clk);
    in_error = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_ev_q.size() != 0 || exp_byte_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_done", exp_ev_q.size() + exp_byte_q.size(), 0);
    idle(2);
  endtask

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [7:0] body_ch();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'h21 || b == 8'h24 || b == 8'h2A);
    return b;
  endfunction

  function automatic logic [7:0] junk_ch();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'h21 || b == 8'h24);
    return b;
  endfunction

  function automatic logic [7:0] bad_hex_ch();
    logic [7:0] cand [9] = '{8'h67, 8'h61, 8'h47, 8'h3A, 8'h40, 8'h2F, 8'h00, 8'hFF, 8'h2A};
    return cand[$urandom_range(0, 8)];
  endfunction

  function automatic logic [7:0] pick_start();
    return ($urandom_range(0, 1) == 1) ? 8'h21 : 8'h24;
  endfunction

  function automatic logic [7:0] xor_body();
    logic [7:0] x = 8'h00;
    foreach (body_q[i]) x ^= body_q[i];
    return x;
  endfunction

  task automatic make_body(input int len);
    body_q.delete();
    for (int i = 0; i < len; i++) body_q.push_back(body_ch());
  endtask

  task automatic expect_good(input logic [7:0] s);
    exp_ev_q.push_back(EV_OK);
    exp_byte_q.push_back({(body_q.size() == 0), s});
    foreach (body_q[i]) exp_byte_q.push_back({(i == body_q.size() - 1), body_q[i]});
  endtask

  task automatic send_frame(input logic [7:0] s, input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] cr, input logic [7:0] lf);
    send_byte(s);
    foreach (body_q[i]) send_byte(body_q[i]);
    send_byte(8'h2A);
    send_byte(hi);
    send_byte(lo);
    send_byte(cr);
    send_byte(lf);
  endtask

  task automatic send_good(input logic [7:0] s);
    logic [7:0] c;
    c = xor_body();
    send_frame(s, hex_ch(c[7:4]), hex_ch(c[3:0]), 8'h0D, 8'h0A);
  endtask

  task automatic random_sentence();
    int         kind, len, k, p;
    logic [7:0] s, c, b, tail [4];
    for (int i = $urandom_range(0, 3); i > 0; i--) send_byte(junk_ch());
    if ($urandom_range(0, 4) == 0) send_err();
    kind = $urandom_range(0, 6);
    s    = pick_start();
    len  = ($urandom_range(0, 3) == 0) ? MAX_LEN - 1 : $urandom_range(0, 20);
    make_body(len);
    c = xor_body();
    case (kind)
      0: begin
        expect_good(s);
        send_good(s);
      end
      1: begin
        exp_ev_q.push_back(4'd4);
        c = c ^ 8'($urandom_range(1, 255));
        send_frame(s, hex_ch(c[7:4]), hex_ch(c[3:0]), 8'h0D, 8'h0A);
      end
      2: begin
        exp_ev_q.push_back(4'd3);
        if ($urandom_range(0, 1) == 1) send_frame(s, bad_hex_ch(), hex_ch(c[3:0]), 8'h0D, 8'h0A);
        else                           send_frame(s, hex_ch(c[7:4]), bad_hex_ch(), 8'h0D, 8'h0A);
      end
      3: begin
        exp_ev_q.push_back(4'd5);
        if ($urandom_range(0, 1) == 1) begin
          do b = ($urandom_range(0, 1) == 1) ? 8'h0A : junk_ch(); while (b == 8'h0D);
          send_frame(s, hex_ch(c[7:4]), hex_ch(c[3:0]), b, 8'h0A);
        end else begin
          do b = junk_ch(); while (b == 8'h0A);
          send_frame(s, hex_ch(c[7:4]), hex_ch(c[3:0]), 8'h0D, b);
        end
      end
      4: begin
        exp_ev_q.push_back(4'd2);
        make_body(MAX_LEN + $urandom_range(0, 1));
        send_byte(s);
        foreach (body_q[i]) send_byte(body_q[i]);
      end
      5: begin
        exp_ev_q.push_back(4'd1);
        k = $urandom_range(0, len);
        send_byte(s);
        for (int i = 0; i < k; i++) send_byte(body_q[i]);
        if (k == len) begin
          tail = '{8'h2A, hex_ch(c[7:4]), hex_ch(c[3:0]), 8'h0D};
          p = $urandom_range(0, 4);
          for (int j = 0; j < p; j++) send_byte(tail[j]);
        end
        send_err();
      end
      default: begin
        exp_ev_q.push_back(4'd6);
        make_body($urandom_range(0, 5));
        send_byte(s);
        foreach (body_q[i]) send_byte(body_q[i]);
        s = pick_start();
        make_body(len);
        expect_good(s);
        send_good(s);
      end
    endcase
    wait_done();
  endtask

  initial begin
    // reset values
    idle(2);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_ok", sentence_ok, 0);
    check_eq("rst_bad", sentence_bad, 0);
    check_eq("rst_err_code", err_code, 0);
    reset_n = 1'b1;
    idle(3);

    // good sentence, exact timing with out_ready held high
    rdy_mode = 0;
    body_q = '{8'h41, 8'h42};
    expect_good(8'h24);
    send_frame(8'h24, 8'h30, 8'h33, 8'h0D, 8'h0A);
    check_eq("t1_ok_pulse", sentence_ok, 1);
    check_eq("t1_valid_e1", out_valid, 0);
    idle(1);
    check_eq("t1_ok_single", sentence_ok, 0);
    check_eq("t1_valid_e2", out_valid, 0);
    idle(1);
    check_eq("t1_valid_rise", out_valid, 1);
    check_eq("t1_byte0", out_data, 8'h24);
    idle(1);
    check_eq("t1_byte1", {out_valid, out_last, out_data}, {2'b10, 8'h41});
    idle(1);
    check_eq("t1_byte2", {out_valid, out_last, out_data}, {2'b11, 8'h42});
    idle(1);
    check_eq("t1_valid_fall", out_valid, 0);
    wait_done();

    // checksum mismatch
    exp_ev_q.push_back(4'd4);
    send_frame(8'h24, 8'h30, 8'h34, 8'h0D, 8'h0A);
    check_eq("t2_bad_code", {sentence_bad, err_code}, 4'hC);
    wait_done();

    // backpressure: first byte held for five cycles
    rdy_mode = 2;
    body_q = '{8'h41};
    expect_good(8'h21);
    send_frame(8'h21, 8'h34, 8'h31, 8'h0D, 8'h0A);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hold", {out_valid, out_last, out_data}, {2'b10, 8'h21});
      idle(1);
    end
    rdy_mode = 0;
    wait_done();

    // restart mid-sentence, then a good one
    exp_ev_q.push_back(4'd6);
    send_byte(8'h24);
    send_byte(8'h41);
    send_byte(8'h42);
    body_q = '{8'h43};
    expect_good(8'h24);
    send_frame(8'h24, 8'h34, 8'h33, 8'h0D, 8'h0A);
    wait_done();

    // longest legal sentence, then one body byte too many
    make_body(MAX_LEN - 1);
    expect_good(8'h21);
    send_good(8'h21);
    wait_done();
    exp_ev_q.push_back(4'd2);
    make_body(MAX_LEN + 1);
    send_byte(8'h24);
    foreach (body_q[i]) send_byte(body_q[i]);
    wait_done();

    // UART error in body, then the framer must accept a fresh sentence
    exp_ev_q.push_back(4'd1);
    send_byte(8'h24);
    send_byte(8'h41);
    send_byte(8'h42);
    send_err();
    check_eq("t5_uart_code", {sentence_bad, err_code}, 4'h9);
    body_q = '{8'h41};
    expect_good(8'h24);
    send_good(8'h24);
    wait_done();

    // bad hex digit and missing CR
    exp_ev_q.push_back(4'd3);
    body_q = '{8'h41};
    send_frame(8'h24, 8'h34, 8'h67, 8'h0D, 8'h0A);
    wait_done();
    exp_ev_q.push_back(4'd5);
    foreach (body_q[i]) begin end
    send_byte(8'h24);
    send_byte(8'h41);
    send_byte(8'h2A);
    send_byte(8'h34);
    send_byte(8'h31);
    send_byte(8'h0A);
    wait_done();

    // bytes and errors during drain are dropped
    rdy_mode = 2;
    body_q = '{8'h41, 8'h42};
    expect_good(8'h24);
    send_good(8'h24);
    body_q = '{8'h58};
    send_good(8'h24);
    send_err();
    rdy_mode = 0;
    wait_done();

    // inter-character timeout
    send_byte(8'h24);
`ifdef NMEA_TIMEOUT_EN
    exp_ev_q.push_back(4'd7);
    send_byte(8'h41);
    idle(TO_CYC + 20);
    check_eq("t7_timeout_seen", exp_ev_q.size(), 0);
`else
    send_byte(8'h41);
    idle(TO_CYC + 50);
    body_q = '{8'h41};
    expect_good(8'h24);
    send_byte(8'h2A);
    send_byte(8'h34);
    send_byte(8'h31);
    send_byte(8'h0D);
    send_byte(8'h0A);
`endif
    wait_done();

    // reset in the middle of a drain
    rdy_mode = 2;
    body_q = '{8'h41, 8'h42, 8'h43};
    expect_good(8'h24);
    send_good(8'h24);
    idle(2);
    check_eq("t8_valid_before", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check_eq("t8_valid_async", out_valid, 0);
    check_eq("t8_last_async", out_last, 0);
    exp_byte_q.delete();
    idle(2);
    reset_n = 1'b1;
    rdy_mode = 0;
    idle(3);
    check_eq("t8_no_resume", out_valid, 0);
    body_q = '{8'h31, 8'h32};
    expect_good(8'h21);
    send_good(8'h21);
    wait_done();

    // randomized sentences
    gap_en = 1'b1;
    for (int it = 0; it < 60; it++) begin
      rdy_mode = $urandom_range(0, 1);
      random_sentence();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
